hue_wheel_fader: RTL

Parametrised RGB colour-wheel generator producing three PWM duty values that cycle through six hue phases (R→Y→G→C→B→M→R). It is the single-clock successor to the team's fixed fader. It adds synchronous reset, configurable resolution and timing, forward/reverse direction, pause, and soft restart. Status outputs (phase, step tick, wrap pulse) are provided for downstream sequencing. Outputs feed the per-channel PWM comparators directly.

---
 rtl/hue_wheel_fader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/hue_wheel_fader.sv
// Six-phase RGB colour-wheel generator: a prescaler paces steps through R->Y->G->C->B->M,
// producing registered PWM duty values plus phase, step and wrap status.
module hue_wheel_fader #(
  parameter int STEP_INTERVAL   = 8000,
  parameter int STEPS_PER_PHASE = 250,
  parameter int PWM_MAX         = 1250,
  parameter int WIDTH           = $clog2(PWM_MAX + 1),
  parameter int STEP_VAL        = PWM_MAX / STEPS_PER_PHASE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] R_value,
  output logic [WIDTH-1:0] G_value,
  output logic [WIDTH-1:0] B_value,
  output logic [2:0]       phase,
  output logic             step_tick,
  output logic             wrap_pulse
);

  localparam int CW = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam int SW = $clog2(STEPS_PER_PHASE);

  localparam logic [CW-1:0]    CNT_LAST = CW'(STEP_INTERVAL - 1);
  localparam logic [SW-1:0]    IDX_LAST = SW'(STEPS_PER_PHASE - 1);
  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(PWM_MAX);
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP_VAL);

  typedef enum logic [2:0] {
    PH_RED     = 3'd0,
    PH_YELLOW  = 3'd1,
    PH_GREEN   = 3'd2,
    PH_CYAN    = 3'd3,
    PH_BLUE    = 3'd4,
    PH_MAGENTA = 3'd5
  } phase_t;

  typedef enum logic [1:0] {
    MODE_FWD     = 2'b00,
    MODE_REV     = 2'b01,
    MODE_PAUSE   = 2'b10,
    MODE_RESTART = 2'b11
  } mode_t;

  mode_t            mode_s;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [SW-1:0]    idx_q,   idx_d;
  phase_t           phase_q, phase_d;
  logic [WIDTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             phase_valid;

  assign mode_s      = mode_t'(mode);
  assign phase_valid = (phase_q <= PH_MAGENTA);

  function automatic phase_t phase_next(input phase_t p);
    case (p)
      PH_RED:     phase_next = PH_YELLOW;
      PH_YELLOW:  phase_next = PH_GREEN;
      PH_GREEN:   phase_next = PH_CYAN;
      PH_CYAN:    phase_next = PH_BLUE;
      PH_BLUE:    phase_next = PH_MAGENTA;
      default:    phase_next = PH_RED;
    endcase
  endfunction

  function automatic phase_t phase_prev(input phase_t p);
    case (p)
      PH_RED:     phase_prev = PH_MAGENTA;
      PH_YELLOW:  phase_prev = PH_RED;
      PH_GREEN:   phase_prev = PH_YELLOW;
      PH_CYAN:    phase_prev = PH_GREEN;
      PH_BLUE:    phase_prev = PH_CYAN;
      default:    phase_prev = PH_BLUE;
    endcase
  endfunction

  // Prescaler, step index and phase; an illegal phase (6/7) reloads the reset state.
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (!phase_valid || mode_s == MODE_RESTART) begin
      cnt_d   = '0;
      idx_d   = '0;
      phase_d = PH_RED;
    end else if (en && mode_s != MODE_PAUSE) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        if (mode_s == MODE_REV) begin
          if (idx_q != '0) begin
            idx_d = idx_q - SW'(1);
          end else begin
            idx_d   = IDX_LAST;
            phase_d = phase_prev(phase_q);
            wrap_d  = (phase_q == PH_RED);
          end
        end else begin
          if (idx_q != IDX_LAST) begin
            idx_d = idx_q + SW'(1);
          end else begin
            idx_d   = '0;
            phase_d = phase_next(phase_q);
            wrap_d  = (phase_q == PH_MAGENTA);
          end
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Duty values derive from the next phase/index so they register alongside them.
  always_comb begin
    logic [WIDTH-1:0] up;
    logic [WIDTH-1:0] dn;
    up  = WIDTH'(idx_d) * STEP_W;
    dn  = MAX_W - up;
    r_d = '0;
    g_d = '0;
    b_d = '0;
    case (phase_d)
      PH_RED:     begin r_d = MAX_W; g_d = up;    end
      PH_YELLOW:  begin r_d = dn;    g_d = MAX_W; end
      PH_GREEN:   begin g_d = MAX_W; b_d = up;    end
      PH_CYAN:    begin g_d = dn;    b_d = MAX_W; end
      PH_BLUE:    begin r_d = up;    b_d = MAX_W; end
      PH_MAGENTA: begin r_d = MAX_W; b_d = dn;    end
      default:    begin r_d = MAX_W;              end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      phase_q <= PH_RED;
      r_q     <= MAX_W;
      g_q     <= '0;
      b_q     <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign R_value    = r_q;
  assign G_value    = g_q;
  assign B_value    = b_q;
  assign phase      = phase_q;
  assign step_tick  = tick_q;
  assign wrap_pulse = wrap_q;

endmodule
